// File: rtl/windup_burst_arbiter.sv
// Round-robin arbiter sharing one wind-up pulse source among REQ requesters.
// Each grant loads a burst length, then gates clk_en for exactly that many cycles.
module windup_burst_arbiter #(
    parameter int REQ = 4,
    parameter int BIT = 16
) (
    input  logic               clk_in,
    input  logic               rst,
    input  logic [REQ-1:0]     req,
    input  logic [REQ*BIT-1:0] burst_len,
    output logic [REQ-1:0]     grant,
    output logic [REQ-1:0]     done,
    output logic               wr_en,
    output logic [BIT-1:0]     wind,
    output logic               clk_en,
    output logic               busy,
    output logic [BIT-1:0]     remaining
);
    localparam int PW = (REQ > 1) ? $clog2(REQ) : 1;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t         state_q, state_d;
    logic [REQ-1:0] grant_q, grant_d;
    logic [PW-1:0]  gidx_q, gidx_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [BIT-1:0] wind_q, wind_d;
    logic [BIT-1:0] rem_q, rem_d;
    logic [PW-1:0]  sel_idx;
    logic [BIT-1:0] sel_len;
    logic           sel_vld;

    // Search descends so the candidate closest after the pointer wins.
    always_comb begin
        int j;
        j       = 0;
        sel_vld = 1'b0;
        sel_idx = '0;
        for (int k = REQ; k >= 1; k--) begin
            j = int'(ptr_q) + k;
            if (j >= REQ) j = j - REQ;
            if (req[PW'(j)]) begin
                sel_vld = 1'b1;
                sel_idx = PW'(j);
            end
        end
    end

    always_comb begin
        sel_len = '0;
        for (int i = 0; i < REQ; i++) begin
            if (sel_idx == PW'(i)) sel_len = burst_len[i*BIT +: BIT];
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        gidx_d  = gidx_q;
        ptr_d   = ptr_q;
        wind_d  = wind_q;
        rem_d   = rem_q;
        unique case (state_q)
            IDLE: begin
                if (sel_vld) begin
                    grant_d = REQ'(1) << sel_idx;
                    gidx_d  = sel_idx;
                    wind_d  = sel_len;
                    state_d = (sel_len == '0) ? DONE : LOAD;
                end
            end
            LOAD: begin
                rem_d   = wind_q;
                state_d = RUN;
            end
            RUN: begin
                // Saturate at zero so a corrupted count can never wrap.
                if (rem_q != '0) rem_d = rem_q - BIT'(1);
                if (rem_q <= BIT'(1)) state_d = DONE;
            end
            DONE: begin
                ptr_d   = gidx_q;
                grant_d = '0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            gidx_q  <= '0;
            ptr_q   <= PW'(REQ - 1);
            wind_q  <= '0;
            rem_q   <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            gidx_q  <= gidx_d;
            ptr_q   <= ptr_d;
            wind_q  <= wind_d;
            rem_q   <= rem_d;
        end
    end

    assign grant     = grant_q;
    assign done      = (state_q == DONE) ? grant_q : '0;
    assign wr_en     = (state_q == LOAD);
    assign clk_en    = (state_q == RUN);
    assign busy      = (state_q != IDLE);
    assign wind      = wind_q;
    assign remaining = rem_q;

endmodule

// File: tb/tb_windup_burst_arbiter.sv
// Scoreboard bench for windup_burst_arbiter: a driver predicts each grant from
// the round-robin rule, a monitor checks every burst the DUT presents.
module tb_windup_burst_arbiter;
    localparam int REQ = 4;
    localparam int BIT = 16;

    typedef struct {
        int idx;
        int len;
    } exp_t;

    logic               clk_in = 1'b0;
    logic               rst = 1'b1;
    logic [REQ-1:0]     req = '0;
    logic [REQ*BIT-1:0] burst_len = '0;
    logic [REQ-1:0]     grant;
    logic [REQ-1:0]     done;
    logic               wr_en;
    logic [BIT-1:0]     wind;
    logic               clk_en;
    logic               busy;
    logic [BIT-1:0]     remaining;

    int   checks = 0;
    int   errors = 0;
    int   ptr_m  = REQ - 1;
    exp_t exp_q[$];

    windup_burst_arbiter #(.REQ(REQ), .BIT(BIT)) dut (
        .clk_in    (clk_in),
        .rst       (rst),
        .req       (req),
        .burst_len (burst_len),
        .grant     (grant),
        .done      (done),
        .wr_en     (wr_en),
        .wind      (wind),
        .clk_en    (clk_en),
        .busy      (busy),
        .remaining (remaining)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_zero_outputs(input string tag);
        chk({tag, "_grant"}, int'(grant), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_clk_en"}, int'(clk_en), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_wind"}, int'(wind), 0);
        chk({tag, "_remaining"}, int'(remaining), 0);
    endtask

    task automatic set_len(input int i, input int v);
        burst_len[i*BIT +: BIT] = BIT'(v);
    endtask

    // Issue a request pattern, predict the winner and wait for its done pulse.
    task automatic do_arb(input logic [REQ-1:0] mask, input bit keep);
        int   idx;
        int   j;
        bit   got;
        exp_t e;
        req = mask;
        idx = -1;
        for (int k = 1; k <= REQ; k++) begin
            j = (ptr_m + k) % REQ;
            if (idx < 0 && mask[j]) idx = j;
        end
        e.idx = idx;
        e.len = int'(burst_len[idx*BIT +: BIT]);
        exp_q.push_back(e);
        got = 1'b0;
        for (int c = 0; c < 100 && !got; c++) begin
            @(negedge clk_in);
            got = done[idx];
        end
        chk("done_seen", int'(got), 1);
        ptr_m = idx;
        if (!keep) req[idx] = 1'b0;
    endtask

    exp_t cur;
    bit   active = 1'b0;
    int   cyc, nclk, nwr;

    always @(negedge clk_in or posedge rst) begin
        if (rst) begin
            active = 1'b0;
        end else begin
            chk("busy_eq_grant_nz", int'(busy), int'(grant != '0));
            if (!active && grant != '0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_grant", int'(grant), 0);
                end else begin
                    cur    = exp_q.pop_front();
                    active = 1'b1;
                    cyc    = 0;
                    nclk   = 0;
                    nwr    = 0;
                    chk("grant_onehot", int'(grant), 1 << cur.idx);
                end
            end
            if (active) begin
                if (wr_en) begin
                    nwr++;
                    chk("wind", int'(wind), cur.len);
                    chk("wr_en_cycle", cyc, 0);
                end
                if (clk_en) begin
                    chk("remaining", int'(remaining), cur.len - nclk);
                    nclk++;
                end
                if (done != '0) begin
                    chk("done_eq_grant", int'(done), 1 << cur.idx);
                    chk("clk_en_count", nclk, cur.len);
                    chk("wr_en_count", nwr, (cur.len != 0) ? 1 : 0);
                    chk("done_latency", cyc, (cur.len == 0) ? 0 : cur.len + 1);
                    chk("remaining_end", int'(remaining), 0);
                    active = 1'b0;
                end
                cyc++;
            end else begin
                chk("idle_done", int'(done), 0);
                chk("idle_wr_en", int'(wr_en), 0);
                chk("idle_clk_en", int'(clk_en), 0);
            end
        end
    end

    initial begin
        int   n;
        exp_t e;
        logic [REQ-1:0] m;

        repeat (2) @(negedge clk_in);
        chk_zero_outputs("reset");
        rst = 1'b0;
        @(negedge clk_in);

        for (int i = 0; i < REQ; i++) set_len(i, 2);
        for (int n5 = 0; n5 < 5; n5++) do_arb(4'b1111, 1'b1);
        req = '0;

        set_len(2, 0);
        do_arb(4'b0100, 1'b0);
        set_len(0, 3);
        do_arb(4'b0001, 1'b0);
        set_len(1, 4);
        do_arb(4'b0011, 1'b0);
        set_len(1, 15);
        do_arb(4'b0010, 1'b0);

        for (int r = 0; r < 60; r++) begin
            for (int i = 0; i < REQ; i++) set_len(i, int'($urandom_range(0, 6)));
            m = REQ'($urandom_range(1, (1 << REQ) - 1));
            do_arb(m, 1'(($urandom_range(0, 1))));
        end
        req = '0;
        repeat (3) @(negedge clk_in);

        set_len(0, 5);
        req   = 4'b0001;
        e.idx = 0;
        e.len = 5;
        exp_q.push_back(e);
        n = 0;
        for (int c = 0; c < 50 && n < 3; c++) begin
            @(negedge clk_in);
            if (clk_en) n++;
        end
        chk("abort_reached", n, 3);
        #2;
        rst = 1'b1;
        req = '0;
        #1;
        chk_zero_outputs("abort");
        @(negedge clk_in);
        rst   = 1'b0;
        ptr_m = REQ - 1;
        repeat (2) @(negedge clk_in);
        do_arb(4'b0001, 1'b0);
        req = '0;
        repeat (3) @(negedge clk_in);

        chk("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
